// File: rtl/fifoa_rr_reader.sv
// fifoa_rr_reader
//   Read-side drain engine for the 10-lane byte FIFO bank. It scans the lanes
//   round-robin, pulses a one-hot read enable, captures the FIFO's registered
//   dout one cycle later, and presents the byte on a valid/ready stream tagged
//   with its source lane. Up to MAX_BURST bytes are taken from one lane before
//   the pointer moves on, so each lane's context stays contiguous downstream.
//
// Ports
//   clk_rd     read-domain clock of the FIFO bank
//   rst_n      asynchronous active-low reset
//   rdempty    per-lane FIFO empty flags
//   fifo_dout  lane i byte on [8i+7:8i], valid the cycle after rd_vld[i]
//   lane_en    per-lane enable; disabled lanes are skipped
//   rd_vld     one-hot FIFO read enables, single-cycle pulses
//   byte_out   captured byte
//   byte_lane  source lane of byte_out
//   byte_vld   byte_out valid
//   byte_rdy   downstream accept
//   idle       high while scanning with no eligible lane
//   byte_cnt   bytes accepted downstream, wraps naturally
module fifoa_rr_reader #(
    parameter int NLANE     = 10,
    parameter int MAX_BURST = 4
) (
    input  logic               clk_rd,
    input  logic               rst_n,
    input  logic [NLANE-1:0]   rdempty,
    input  logic [NLANE*8-1:0] fifo_dout,
    input  logic [NLANE-1:0]   lane_en,
    output logic [NLANE-1:0]   rd_vld,
    output logic [7:0]         byte_out,
    output logic [3:0]         byte_lane,
    output logic               byte_vld,
    input  logic               byte_rdy,
    output logic               idle,
    output logic [15:0]        byte_cnt
);
    localparam int LW = 4;

    typedef enum logic [1:0] {SCAN, READ, CAPT, HOLD} state_t;

    state_t                  state;
    logic [LW-1:0]           ptr;
    logic [LW-1:0]           sel;
    logic [3:0]              burst_cnt;
    logic [NLANE-1:0]        elig;
    logic [NLANE-1:0][7:0]   dout_a;
    logic                    found;
    logic [LW-1:0]           pick;
    logic [LW-1:0]           cand;
    logic                    burst_more;

    // (a + k) mod NLANE for k < NLANE; one conditional subtract is enough.
    function automatic logic [LW-1:0] lane_add(logic [LW-1:0] a, int k);
        int s;
        s = int'(a) + k;
        if (s >= NLANE) s = s - NLANE;
        return LW'(s);
    endfunction

    function automatic logic [NLANE-1:0] onehot(logic [LW-1:0] l);
        logic [NLANE-1:0] v;
        v    = '0;
        v[l] = 1'b1;
        return v;
    endfunction

    assign elig   = ~rdempty & lane_en;
    assign dout_a = fifo_dout;

    // First eligible lane at or after ptr, wrapping; a lane just served sits
    // at the far end of the search because ptr was advanced past it.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NLANE; k++) begin
            cand = lane_add(ptr, k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Burst continues only if the lane is still readable right now, so a
    // lane that emptied or was disabled mid-burst is never read again.
    assign burst_more = (int'(burst_cnt) + 1 < MAX_BURST) && elig[sel];

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            ptr       <= '0;
            sel       <= '0;
            burst_cnt <= '0;
            rd_vld    <= '0;
            byte_out  <= '0;
            byte_lane <= '0;
            byte_vld  <= 1'b0;
            byte_cnt  <= '0;
            idle      <= 1'b0;
        end else begin
            rd_vld <= '0;
            idle   <= 1'b0;
            case (state)
                SCAN: begin
                    if (found) begin
                        sel       <= pick;
                        burst_cnt <= '0;
                        rd_vld    <= onehot(pick);
                        state     <= READ;
                    end else begin
                        idle <= 1'b1;
                    end
                end
                READ: state <= CAPT;
                CAPT: begin
                    byte_out  <= dout_a[sel];
                    byte_lane <= sel;
                    byte_vld  <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    // Single-entry output buffer: no new read until accepted.
                    if (byte_rdy) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        byte_vld <= 1'b0;
                        if (burst_more) begin
                            burst_cnt <= burst_cnt + 4'd1;
                            rd_vld    <= onehot(sel);
                            state     <= READ;
                        end else begin
                            ptr   <= lane_add(sel, 1);
                            state <= SCAN;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_fifoa_rr_reader.sv
module tb_fifoa_rr_reader;
    logic        clk_rd = 1'b0;
    logic        rst_n  = 1'b0;
    logic [9:0]  rdempty;
    logic [79:0] fifo_dout;
    logic [9:0]  lane_en = 10'h3FF;
    logic [9:0]  rd_vld;
    logic [7:0]  byte_out;
    logic [3:0]  byte_lane;
    logic        byte_vld;
    logic        byte_rdy = 1'b0;
    logic        idle;
    logic [15:0] byte_cnt;

    int tests = 0;
    int fails = 0;

    fifoa_rr_reader #(.NLANE(10), .MAX_BURST(4)) dut (
        .clk_rd(clk_rd), .rst_n(rst_n), .rdempty(rdempty), .fifo_dout(fifo_dout),
        .lane_en(lane_en), .rd_vld(rd_vld), .byte_out(byte_out), .byte_lane(byte_lane),
        .byte_vld(byte_vld), .byte_rdy(byte_rdy), .idle(idle), .byte_cnt(byte_cnt)
    );

    always #5 clk_rd = ~clk_rd;

    // FIFO bank model: registered dout, popped on rd_vld.
    logic [7:0]       mem [10][16];
    int               wp [10];
    int               rp [10];
    logic [9:0][7:0]  dout_q = '0;
    int               uf = 0;
    assign fifo_dout = dout_q;

    always_comb begin
        rdempty = '0;
        for (int i = 0; i < 10; i++) rdempty[i] = (wp[i] == rp[i]);
    end

    always @(posedge clk_rd) begin
        for (int i = 0; i < 10; i++) begin
            if (rd_vld[i]) begin
                if (wp[i] == rp[i]) uf <= uf + 1;
                else begin
                    dout_q[i] <= mem[i][rp[i] % 16];
                    rp[i]     <= rp[i] + 1;
                end
            end
        end
    end

    // Stream and read-enable monitor, sampled mid-cycle.
    logic [7:0] got_b [256];
    logic [3:0] got_l [256];
    logic [9:0] rd_log [256];
    int nb = 0, nr = 0, viol = 0;

    always @(negedge clk_rd) begin
        if (byte_vld && byte_rdy && nb < 256) begin
            got_b[nb] = byte_out;
            got_l[nb] = byte_lane;
            nb = nb + 1;
        end
        if (rd_vld != 10'h0) begin
            if (nr < 256) begin
                rd_log[nr] = rd_vld;
                nr = nr + 1;
            end
            if (byte_vld) viol = viol + 1;
            if ((rd_vld & (rd_vld - 10'h1)) != 10'h0) viol = viol + 1;
        end
    end

    task automatic tick();
        @(posedge clk_rd);
        #1;
    endtask

    task automatic push(input int l, input logic [7:0] b);
        mem[l][wp[l] % 16] = b;
        wp[l] = wp[l] + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int c;
        tick();
        tick();
        c = 0;
        while (!idle && c < budget) begin
            tick();
            c++;
        end
        if (!idle) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: timeout after %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++; if (rd_vld !== 10'h0) begin fails++; $display("FAIL reset_rd_vld: got %h exp 000", rd_vld); end
        tests++; if (byte_vld !== 1'b0) begin fails++; $display("FAIL reset_byte_vld: got %b exp 0", byte_vld); end
        tests++; if (byte_out !== 8'h0) begin fails++; $display("FAIL reset_byte_out: got %h exp 00", byte_out); end
        tests++; if (byte_lane !== 4'h0) begin fails++; $display("FAIL reset_byte_lane: got %h exp 0", byte_lane); end
        tests++; if (byte_cnt !== 16'h0) begin fails++; $display("FAIL reset_byte_cnt: got %h exp 0000", byte_cnt); end
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL reset_idle: got %b exp 0", idle); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle_empty: got %b exp 1", idle); end
    endtask

    task automatic test_single();
        int n0, r0;
        do_reset();
        byte_rdy = 1'b1;
        n0 = nb; r0 = nr;
        push(3, 8'hA1);
        push(3, 8'hA2);
        wait_idle(60);
        tests++; if (nb - n0 !== 2) begin fails++; $display("FAIL single_count: got %0d exp 2", nb - n0); end
        tests++; if (nr - r0 !== 2) begin fails++; $display("FAIL single_reads: got %0d exp 2", nr - r0); end
        tests++; if (rd_log[r0] !== 10'h008) begin fails++; $display("FAIL single_rd0: got %h exp 008", rd_log[r0]); end
        tests++; if (rd_log[r0+1] !== 10'h008) begin fails++; $display("FAIL single_rd1: got %h exp 008", rd_log[r0+1]); end
        tests++; if (got_b[n0] !== 8'hA1 || got_l[n0] !== 4'd3) begin fails++; $display("FAIL single_b0: got %h/%0d exp a1/3", got_b[n0], got_l[n0]); end
        tests++; if (got_b[n0+1] !== 8'hA2 || got_l[n0+1] !== 4'd3) begin fails++; $display("FAIL single_b1: got %h/%0d exp a2/3", got_b[n0+1], got_l[n0+1]); end
        tests++; if (byte_cnt !== 16'd2) begin fails++; $display("FAIL single_cnt: got %0d exp 2", byte_cnt); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL single_idle: got %b exp 1", idle); end
    endtask

    task automatic test_burst();
        int n0, j, ln, cnt, kk;
        do_reset();
        byte_rdy = 1'b1;
        n0 = nb;
        for (int k = 0; k < 6; k++) begin
            push(0, 8'(k));
            push(5, 8'(8'h50 + k));
            push(9, 8'(8'h90 + k));
        end
        wait_idle(300);
        tests++; if (nb - n0 !== 18) begin fails++; $display("FAIL burst_count: got %0d exp 18", nb - n0); end
        j = 0;
        for (int r = 0; r < 2; r++) begin
            for (int li = 0; li < 3; li++) begin
                ln  = (li == 0) ? 0 : (li == 1) ? 5 : 9;
                cnt = (r == 0) ? 4 : 2;
                for (int k = 0; k < cnt; k++) begin
                    kk = r * 4 + k;
                    tests++;
                    if (got_l[n0+j] !== 4'(ln) || got_b[n0+j] !== 8'(ln * 16 + kk)) begin
                        fails++;
                        $display("FAIL burst_order[%0d]: got %0d/%h exp %0d/%h", j, got_l[n0+j], got_b[n0+j], ln, 8'(ln * 16 + kk));
                    end
                    j++;
                end
            end
        end
        tests++; if (byte_cnt !== 16'd18) begin fails++; $display("FAIL burst_cnt: got %0d exp 18", byte_cnt); end
    endtask

    task automatic test_backpressure();
        int c;
        do_reset();
        byte_rdy = 1'b0;
        push(2, 8'h20);
        push(2, 8'h21);
        push(2, 8'h22);
        c = 0;
        while (!byte_vld && c < 20) begin
            tick();
            c++;
        end
        tests++; if (byte_vld !== 1'b1) begin fails++; $display("FAIL bp_first_vld: got %b exp 1", byte_vld); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (byte_vld !== 1'b1 || byte_out !== 8'h20 || byte_lane !== 4'd2 || rd_vld !== 10'h0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got vld=%b out=%h lane=%0d rd=%h exp 1/20/2/000", i, byte_vld, byte_out, byte_lane, rd_vld);
            end
            tick();
        end
        byte_rdy = 1'b1;
        tick();
        tests++; if (rd_vld !== 10'h004) begin fails++; $display("FAIL bp_next_read: got %h exp 004", rd_vld); end
        wait_idle(60);
        tests++; if (byte_cnt !== 16'd3) begin fails++; $display("FAIL bp_cnt: got %0d exp 3", byte_cnt); end
    endtask

    task automatic test_lane_en();
        int n0;
        do_reset();
        byte_rdy = 1'b1;
        lane_en  = 10'h3FE;
        n0 = nb;
        push(0, 8'h01);
        push(0, 8'h02);
        push(1, 8'h11);
        push(1, 8'h12);
        push(1, 8'h13);
        wait_idle(100);
        tests++; if (nb - n0 !== 3) begin fails++; $display("FAIL en_count: got %0d exp 3", nb - n0); end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (got_l[n0+k] !== 4'd1 || got_b[n0+k] !== 8'(8'h11 + k)) begin
                fails++;
                $display("FAIL en_byte[%0d]: got %0d/%h exp 1/%h", k, got_l[n0+k], got_b[n0+k], 8'(8'h11 + k));
            end
        end
        tests++; if (wp[0] - rp[0] !== 2) begin fails++; $display("FAIL en_lane0_untouched: got %0d exp 2", wp[0] - rp[0]); end
        tests++; if (byte_cnt !== 16'd3) begin fails++; $display("FAIL en_cnt: got %0d exp 3", byte_cnt); end
        lane_en = 10'h3FF;
        wait_idle(60);
        tests++; if (nb - n0 !== 5 || got_l[n0+3] !== 4'd0) begin fails++; $display("FAIL en_restore: got %0d/%0d exp 5/0", nb - n0, got_l[n0+3]); end
    endtask

    task automatic test_reset_mid();
        int c, n0;
        bit seen;
        do_reset();
        byte_rdy = 1'b1;
        push(8, 8'h80);
        wait_idle(40);
        push(5, 8'h54);
        push(5, 8'h55);
        seen = 1'b0;
        c = 0;
        while (!seen && c < 40) begin
            tick();
            c++;
            if (byte_vld && byte_out == 8'h55) begin
                byte_rdy = 1'b0;
                seen = 1'b1;
            end
        end
        tests++; if (!seen) begin fails++; $display("FAIL rm_pending: got none exp byte 55"); end
        tick();
        tick();
        tests++; if (byte_vld !== 1'b1 || byte_cnt !== 16'd2) begin fails++; $display("FAIL rm_hold: got %b/%0d exp 1/2", byte_vld, byte_cnt); end
        rst_n = 1'b0;
        #1;
        tests++; if (byte_vld !== 1'b0) begin fails++; $display("FAIL rm_vld_async: got %b exp 0", byte_vld); end
        tests++; if (rd_vld !== 10'h0) begin fails++; $display("FAIL rm_rd_async: got %h exp 000", rd_vld); end
        tests++; if (byte_cnt !== 16'd0) begin fails++; $display("FAIL rm_cnt_async: got %0d exp 0", byte_cnt); end
        tick();
        rst_n    = 1'b1;
        byte_rdy = 1'b1;
        n0 = nb;
        push(7, 8'h77);
        push(1, 8'h11);
        wait_idle(60);
        tests++; if (nb - n0 !== 2) begin fails++; $display("FAIL rm_after_count: got %0d exp 2", nb - n0); end
        tests++; if (got_l[n0] !== 4'd1 || got_b[n0] !== 8'h11) begin fails++; $display("FAIL rm_ptr0: got %0d/%h exp 1/11", got_l[n0], got_b[n0]); end
        tests++; if (got_l[n0+1] !== 4'd7 || got_b[n0+1] !== 8'h77) begin fails++; $display("FAIL rm_second: got %0d/%h exp 7/77", got_l[n0+1], got_b[n0+1]); end
        tests++; if (byte_cnt !== 16'd2) begin fails++; $display("FAIL rm_cnt_after: got %0d exp 2", byte_cnt); end
    endtask

    task automatic test_cnt_wrap();
        int n0;
        do_reset();
        force dut.byte_cnt = 16'hFFFF;
        tick();
        release dut.byte_cnt;
        byte_rdy = 1'b1;
        n0 = nb;
        push(6, 8'h66);
        wait_idle(40);
        tests++; if (byte_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_cnt: got %h exp 0000", byte_cnt); end
        tests++; if (nb - n0 !== 1 || got_b[n0] !== 8'h66) begin fails++; $display("FAIL wrap_byte: got %0d/%h exp 1/66", nb - n0, got_b[n0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_lane_en();
        test_reset_mid();
        test_cnt_wrap();
        tests++; if (uf !== 0) begin fails++; $display("FAIL underflow: got %0d exp 0", uf); end
        tests++; if (viol !== 0) begin fails++; $display("FAIL rd_vld_rules: got %0d exp 0", viol); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifoa_rr_reader.md
Name: fifoa_rr_reader

Overview:
- Read-side drain engine for the 10-lane byte FIFO bank between the bit-plane coder and the MQ coder.
- Scans the 10 `rdempty` flags round-robin and issues one-hot `rd_vld` pulses.
- Captures each FIFO's registered `dout`, one cycle after its read enable.
- Serialises the bytes onto a single valid/ready byte stream tagged with the source lane. Bursts of up to MAX_BURST bytes per lane keep the context stream contiguous.

Parameters:
- NLANE, 10, number of FIFO lanes (fixed 10 for this bank; pointer width 4).
- MAX_BURST, 4, max bytes taken from one lane before the pointer advances (1..15).

Ports:
- clk_rd  input  1  read-domain clock of the FIFO bank
- rst_n  input  1  asynchronous active-low reset
- rdempty  input  10  per-lane FIFO empty flags
- fifo_dout  input  80  lane i data on bits [8i+7:8i]; valid the cycle after rd_vld[i]
- lane_en  input  10  per-lane enable; disabled lanes are skipped
- rd_vld  output  10  one-hot FIFO read enables (single-cycle pulses)
- byte_out  output  8  captured byte
- byte_lane  output  4  source lane of byte_out (0..9)
- byte_vld  output  1  byte_out valid
- byte_rdy  input  1  downstream accept
- idle  output  1  high in SCAN when no lane is eligible
- byte_cnt  output  16  total bytes accepted downstream, wraps at 65535->0

Behaviour:
- Reset values (async on rst_n low): state=SCAN, ptr=0, sel=0, burst_cnt=0, rd_vld=0, byte_out=0, byte_lane=0, byte_vld=0, byte_cnt=0, idle=0.
- Eligibility: lane i is eligible when rdempty[i]==0 and lane_en[i]==1.
- SCAN:
  - Search lanes ptr, ptr+1, ... wrapping 9->0 and take the first eligible lane.
  - If found: sel=lane, burst_cnt=0, next state READ.
  - Else: stay in SCAN and assert idle (registered, visible the following cycle).
- READ:
  - rd_vld[sel]=1 for exactly this cycle; all other bits 0.
  - Next state CAPT.
- CAPT:
  - fifo_dout[sel] is valid this cycle; latch it into byte_out and latch byte_lane=sel.
  - byte_vld=1 from the next cycle. Next state HOLD.
- HOLD:
  - byte_vld=1; byte_out and byte_lane are held stable until byte_rdy.
  - On byte_rdy, byte_cnt increments, byte_vld drops next cycle, and the next state is chosen as follows:
    - If burst_cnt+1 < MAX_BURST and lane sel is still eligible: burst_cnt++, next state READ (same lane).
    - Else: ptr=(sel+1) mod 10, next state SCAN.
  - Without byte_rdy: stay in HOLD with nothing changing.
- Latency: READ to byte_vld is 2 cycles. Best-case throughput is 1 byte per 3 cycles within a burst and 1 byte per 4 cycles across lanes.
- rd_vld is never asserted for a lane whose rdempty was high in the deciding cycle, so the FIFO is never underflowed.
- rd_vld is never asserted while byte_vld is high (single-entry output buffer).
- lane_en dropping mid-burst: the byte already read is still delivered, then the burst ends.
- rdempty rising mid-burst: the burst ends early and the pointer advances.
- Pointer wrap: ptr=9 with lane 9 finished gives ptr=0.
- Simultaneously eligible lanes are served strictly in round-robin order from ptr. A lane just served has lowest priority.
- Reset mid-operation: any captured-but-unaccepted byte is dropped; rd_vld is forced to 0 immediately (asynchronously).

Test Plan:
- After reset: lane 3 holds 0xA1,0xA2 and all lanes are enabled, byte_rdy=1 → rd_vld=0x008 twice; bytes 0xA1 then 0xA2 appear with byte_lane=3; byte_cnt=2; idle=1 afterwards.
- Lanes 0, 5 and 9 each hold 6 bytes, MAX_BURST=4 → order is lane 0 ×4, 5 ×4, 9 ×4, 0 ×2, 5 ×2, 9 ×2; byte_cnt=18.
- Downstream backpressure (byte_rdy=0 for 10 cycles while lane 2 is non-empty) → byte_vld held, byte_out stable, rd_vld stays 0 throughout; after byte_rdy=1 the next read occurs 1 cycle later.
- lane_en=0x3FE while lanes 0 and 1 are both non-empty → lane 0 is never read; all bytes come from lane 1 only.
- rst_n pulsed low while in HOLD with byte 0x55 pending → byte_vld=0 and rd_vld=0 immediately; ptr=0 and byte_cnt=0 after release.
- Start from byte_cnt=65535 and accept one byte → byte_cnt=0.
